rtx_ctrl: RTL and testbench

Retransmit-buffer controller for the OmniXtend core. It sits between the TX framer, the ACK/NAK receive path and the 256-bit retransmit RAM (8 entries × 64 beats). It captures each outgoing frame into a free entry tagged with its sequence number and frees entries on cumulative ACK. On NAK it replays every outstanding frame, oldest first. It owns the single RAM port pair and guarantees that write and read are never asserted in the same cycle.

---
 rtl/rtx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rtx_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtx_ctrl.sv
// rtx_ctrl: 8-entry retransmit ring over a 256-bit RAM; captures frames, frees on cumulative ACK, replays all outstanding frames on NAK.
// Latency: capture writes in the accepting cycle; first replay beat 2 cycles after replay start, then 1 beat/cycle.
// Backpressure: cap_ready_o low when full or replaying; replay stalls on rpl_ready_i. RTX_CTRL_STATS_EN enables rtx_cnt_o.
module rtx_ctrl #(
  parameter int RTX_DATA_PTR = 9,
  parameter int ENTRY_BITS   = 3,
  parameter int SEQ_W        = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid_i,
  output logic                    cap_ready_o,
  input  logic [255:0]            cap_data_i,
  input  logic                    cap_last_i,
  input  logic [SEQ_W-1:0]        cap_seq_i,
  input  logic                    ack_valid_i,
  input  logic [SEQ_W-1:0]        ack_seq_i,
  input  logic                    rtx_req_i,
  output logic                    rtx_busy_o,
  output logic                    rpl_valid_o,
  input  logic                    rpl_ready_i,
  output logic [255:0]            rpl_data_o,
  output logic                    rpl_last_o,
  output logic [SEQ_W-1:0]        rpl_seq_o,
  output logic [255:0]            wrdata_o,
  output logic [RTX_DATA_PTR-1:0] wraddr_o,
  output logic                    we_o,
  output logic [RTX_DATA_PTR-1:0] rdaddr_o,
  output logic                    re_o,
  input  logic [255:0]            rddata_i,
  output logic [ENTRY_BITS:0]     free_cnt_o,
  output logic                    ovf_err_o,
  output logic [15:0]             rtx_cnt_o
);
  localparam int BEAT_BITS = RTX_DATA_PTR - ENTRY_BITS;
  localparam int ENTRIES   = 1 << ENTRY_BITS;
  localparam logic [ENTRY_BITS:0] FULL     = {1'b1, {ENTRY_BITS{1'b0}}};
  localparam logic [BEAT_BITS:0]  OVF_BEAT = {1'b1, {BEAT_BITS{1'b0}}};
  localparam logic [BEAT_BITS:0]  SAT_BEAT = {1'b1, {(BEAT_BITS-1){1'b0}}, 1'b1};
  localparam logic [SEQ_W-1:0]    HALF     = {1'b1, {(SEQ_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, REPLAY} state_t;

  state_t                  state_q, state_d;
  logic [ENTRY_BITS-1:0]   head_q, tail_q, rd_ent_q;
  logic [ENTRY_BITS:0]     count_q, walk_q;
  logic [BEAT_BITS:0]      cap_cnt_q;
  logic [BEAT_BITS-1:0]    rd_beat_q;
  logic [SEQ_W-1:0]        seq_tab [ENTRIES];
  logic [BEAT_BITS-1:0]    len_tab [ENTRIES];
  logic [SEQ_W-1:0]        ack_seq_q, rpl_seq_q;
  logic                    ack_act_q, pend_q, ovf_q;
  logic                    rpl_valid_q, rpl_last_q;

  logic                    cap_fire, cap_drop, commit, do_free;
  logic                    start_rpl, drop_req;
  logic [BEAT_BITS-1:0]    commit_len;
  logic [SEQ_W-1:0]        ack_diff;

  always_comb begin
    state_d     = state_q;
    cap_ready_o = 1'b0;
    start_rpl   = 1'b0;
    drop_req    = 1'b0;
    re_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q && count_q != '0) begin
          start_rpl = 1'b1;
          state_d   = REPLAY;
        end else begin
          drop_req    = pend_q;
          // Async reset holds state at IDLE, so only this branch needs the rst gate
          cap_ready_o = (count_q != FULL) && !rst;
          if (cap_valid_i && cap_ready_o && !cap_last_i) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cap_ready_o = 1'b1;
        if (cap_valid_i && cap_last_i) state_d = IDLE;
      end
      REPLAY: begin
        re_o = (walk_q != '0) && (!rpl_valid_q || rpl_ready_i);
        if (walk_q == '0 && rpl_valid_q && rpl_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beats past the 64th are still accepted so the framer never stalls, but never written
  assign cap_fire   = cap_valid_i && cap_ready_o;
  assign cap_drop   = cap_cnt_q[BEAT_BITS];
  assign commit     = cap_fire && cap_last_i;
  assign commit_len = cap_drop ? {BEAT_BITS{1'b1}} : cap_cnt_q[BEAT_BITS-1:0];
  assign we_o       = cap_fire && !cap_drop;
  assign wraddr_o   = {tail_q, cap_cnt_q[BEAT_BITS-1:0]};
  assign wrdata_o   = cap_data_i;

  assign ack_diff = ack_seq_q - seq_tab[head_q];
  assign do_free  = ack_act_q && (count_q != '0) && (ack_diff < HALF);

  assign rdaddr_o    = {rd_ent_q, rd_beat_q};
  assign rpl_data_o  = rddata_i;
  assign rpl_valid_o = rpl_valid_q;
  assign rpl_last_o  = rpl_last_q;
  assign rpl_seq_o   = rpl_seq_q;
  assign rtx_busy_o  = pend_q || (state_q == REPLAY);
  assign free_cnt_o  = FULL - count_q;
  assign ovf_err_o   = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cap_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      ack_seq_q   <= '0;
      ack_act_q   <= 1'b0;
      pend_q      <= 1'b0;
      rd_ent_q    <= '0;
      rd_beat_q   <= '0;
      walk_q      <= '0;
      rpl_valid_q <= 1'b0;
      rpl_last_q  <= 1'b0;
      rpl_seq_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= cap_fire && (cap_cnt_q == OVF_BEAT);

      if (commit) begin
        tail_q    <= tail_q + 1'b1;
        cap_cnt_q <= '0;
      end else if (cap_fire && cap_cnt_q != SAT_BEAT) begin
        cap_cnt_q <= cap_cnt_q + 1'b1;
      end

      if (do_free) head_q <= head_q + 1'b1;
      if (commit && !do_free)      count_q <= count_q + 1'b1;
      else if (!commit && do_free) count_q <= count_q - 1'b1;

      if (ack_valid_i) begin
        ack_seq_q <= ack_seq_i;
        ack_act_q <= 1'b1;
      end

      // A request arriving in the same cycle as replay start arms one further replay
      pend_q <= rtx_req_i || (pend_q && !start_rpl && !drop_req);

      if (start_rpl) begin
        rd_ent_q  <= head_q;
        rd_beat_q <= '0;
        walk_q    <= count_q;
      end else if (re_o) begin
        if (rd_beat_q == len_tab[rd_ent_q]) begin
          rd_beat_q <= '0;
          rd_ent_q  <= rd_ent_q + 1'b1;
          walk_q    <= walk_q - 1'b1;
        end else begin
          rd_beat_q <= rd_beat_q + 1'b1;
        end
      end

      if (re_o) begin
        rpl_valid_q <= 1'b1;
        rpl_last_q  <= (rd_beat_q == len_tab[rd_ent_q]);
        rpl_seq_q   <= seq_tab[rd_ent_q];
      end else if (rpl_ready_i) begin
        rpl_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_fire && state_q == IDLE) seq_tab[tail_q] <= cap_seq_i;
    if (commit) len_tab[tail_q] <= commit_len;
  end

`ifdef RTX_CTRL_STATS_EN
  logic [15:0] rtx_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rtx_cnt_q <= '0;
    else if (start_rpl && rtx_cnt_q != 16'hFFFF) rtx_cnt_q <= rtx_cnt_q + 1'b1;
  end
  assign rtx_cnt_o = rtx_cnt_q;
`else
  assign rtx_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_rtx_ctrl.sv
// Directed bench for rtx_ctrl with a behavioural 1-cycle-latency RAM and write/replay logs.
module tb_rtx_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cap_valid = 1'b0, cap_ready, cap_last = 1'b0;
  logic [255:0] cap_data = '0;
  logic [21:0]  cap_seq = '0;
  logic         ack_valid = 1'b0;
  logic [21:0]  ack_seq = '0;
  logic         rtx_req = 1'b0, rtx_busy;
  logic         rpl_valid, rpl_ready = 1'b0, rpl_last;
  logic [255:0] rpl_data, wrdata, rddata;
  logic [21:0]  rpl_seq;
  logic [8:0]   wraddr, rdaddr;
  logic         we, re, ovf_err;
  logic [3:0]   free_cnt;
  logic [15:0]  rtx_cnt;

  logic [255:0] mem [512];
  int           wr_log [$];
  logic [255:0] rl_data [$];
  bit           rl_last [$];
  int           rl_seq [$];
  bit           both_seen = 1'b0;
  int           ovf_cnt = 0;
  int           n_vec = 0;
  int           n_err = 0;

`ifdef RTX_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  rtx_ctrl dut (
    .clk(clk), .rst(rst),
    .cap_valid_i(cap_valid), .cap_ready_o(cap_ready), .cap_data_i(cap_data),
    .cap_last_i(cap_last), .cap_seq_i(cap_seq),
    .ack_valid_i(ack_valid), .ack_seq_i(ack_seq),
    .rtx_req_i(rtx_req), .rtx_busy_o(rtx_busy),
    .rpl_valid_o(rpl_valid), .rpl_ready_i(rpl_ready), .rpl_data_o(rpl_data),
    .rpl_last_o(rpl_last), .rpl_seq_o(rpl_seq),
    .wrdata_o(wrdata), .wraddr_o(wraddr), .we_o(we),
    .rdaddr_o(rdaddr), .re_o(re), .rddata_i(rddata),
    .free_cnt_o(free_cnt), .ovf_err_o(ovf_err), .rtx_cnt_o(rtx_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[wraddr] <= wrdata;
    if (re) rddata <= mem[rdaddr];
  end

  always @(negedge clk) begin
    if (we) wr_log.push_back(int'(wraddr));
    if (we && re) both_seen = 1'b1;
    if (ovf_err) ovf_cnt++;
    if (rpl_valid && rpl_ready) begin
      rl_data.push_back(rpl_data);
      rl_last.push_back(rpl_last);
      rl_seq.push_back(int'(rpl_seq));
    end
  end

  function automatic logic [255:0] mkdata(input int seq, input int b);
    return {192'd0, 32'(seq), 32'(b)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; cap_valid = 0; cap_last = 0; ack_valid = 0; rtx_req = 0; rpl_ready = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_frame(input int seq, input int nb);
    int b = 0;
    int guard = 0;
    logic acc;
    while (b < nb) begin
      cap_valid = 1'b1; cap_seq = 22'(seq); cap_data = mkdata(seq, b); cap_last = (b == nb - 1);
      @(negedge clk);
      acc = cap_ready;
      @(posedge clk); #1;
      if (acc) b++;
      guard++;
      if (guard > 500) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: seq %0d stuck at beat %0d, required acceptance", seq, b);
        break;
      end
    end
    cap_valid = 1'b0; cap_last = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    int cyc = 0;
    forever begin
      if (toggle) rpl_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (!rtx_busy) break;
      if (cyc > 3000) begin
        n_vec++; n_err++;
        $display("FAIL replay_timeout: busy=%0d after %0d cycles, required 0", rtx_busy, cyc);
        break;
      end
      cyc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rpl_ready = 1'b0;
  endtask

  task automatic run_replay(input bit toggle);
    rl_data.delete(); rl_last.delete(); rl_seq.delete();
    rtx_req = 1'b1;
    if (!toggle) rpl_ready = 1'b1;
    @(posedge clk); #1;
    rtx_req = 1'b0;
    wait_idle(toggle);
  endtask

  task automatic ack_pulse(input int seq);
    ack_valid = 1'b1; ack_seq = 22'(seq);
    @(posedge clk); #1;
    ack_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({cap_ready, rtx_busy, rpl_valid, rpl_last, we, re, ovf_err} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b required 0000000", {cap_ready, rtx_busy, rpl_valid, rpl_last, we, re, ovf_err});
    end
    n_vec++;
    if (free_cnt !== 4'd8) begin n_err++; $display("FAIL reset_free: got %0d required 8", free_cnt); end
    n_vec++;
    if ({wraddr, rdaddr, rtx_cnt} !== 34'd0) begin
      n_err++; $display("FAIL reset_addr_cnt: wraddr %0d rdaddr %0d rtx_cnt %0d required 0", wraddr, rdaddr, rtx_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cap_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b required 1", cap_ready); end
    n_vec++;
    if (rtx_busy !== 1'b0 || free_cnt !== 4'd8) begin
      n_err++; $display("FAIL post_reset_state: busy %b free %0d required 0/8", rtx_busy, free_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_capture();
    int exp_addr [$];
    int bad = -1;
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 4; i++) exp_addr.push_back(i);
    exp_addr.push_back(64);
    for (int i = 128; i < 192; i++) exp_addr.push_back(i);
    send_frame(10, 4);
    send_frame(11, 1);
    send_frame(12, 64);
    @(negedge clk);
    n_vec++;
    if (wr_log.size() != 69) begin n_err++; $display("FAIL capture_writes: got %0d required 69", wr_log.size()); end
    for (int i = 0; i < wr_log.size() && i < 69; i++)
      if (bad < 0 && wr_log[i] != exp_addr[i]) bad = i;
    n_vec++;
    if (bad >= 0) begin n_err++; $display("FAIL capture_addr[%0d]: got %0d required %0d", bad, wr_log[bad], exp_addr[bad]); end
    n_vec++;
    if (free_cnt !== 4'd5) begin n_err++; $display("FAIL capture_free: got %0d required 5", free_cnt); end
    n_vec++;
    if (mem[131] !== mkdata(12, 3)) begin n_err++; $display("FAIL capture_data: got %h required %h", mem[131], mkdata(12, 3)); end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(20 + i, 1);
    @(negedge clk);
    n_vec++;
    if (free_cnt !== 4'd0) begin n_err++; $display("FAIL full_free: got %0d required 0", free_cnt); end
    @(posedge clk); #1;
    cap_valid = 1'b1; cap_seq = 22'd28; cap_data = mkdata(28, 0); cap_last = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cap_ready !== 1'b0 || we !== 1'b0) begin n_err++; $display("FAIL full_ready: ready %b we %b required 0/0", cap_ready, we); end
    @(posedge clk); #1;
    cap_valid = 1'b0; cap_last = 1'b0;
    ack_pulse(20);
    @(negedge clk);
    n_vec++;
    if (free_cnt !== 4'd1) begin n_err++; $display("FAIL full_ack_free: got %0d required 1", free_cnt); end
    @(posedge clk); #1;
    wr_log.delete();
    send_frame(28, 1);
    @(negedge clk);
    n_vec++;
    if (wr_log.size() != 1 || wr_log[0] != 0) begin
      n_err++; $display("FAIL full_ninth_addr: writes %0d first %0d required 1 write at 0", wr_log.size(), wr_log.size() > 0 ? wr_log[0] : -1);
    end
    n_vec++;
    if (free_cnt !== 4'd0) begin n_err++; $display("FAIL full_ninth_free: got %0d required 0", free_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_replay();
    int seqs [3] = '{5, 6, 7};
    int lens [3] = '{3, 2, 4};
    int idx = 0;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(seqs[f], lens[f]);
    both_seen = 1'b0;
    run_replay(1'b1);
    n_vec++;
    if (rl_data.size() != 9) begin n_err++; $display("FAIL replay_count: got %0d required 9", rl_data.size()); end
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < lens[f]; b++) begin
        n_vec++;
        if (idx >= rl_data.size()) begin
          n_err++; $display("FAIL replay_beat%0d: missing, required seq %0d beat %0d", idx, seqs[f], b);
        end else if (rl_data[idx] !== mkdata(seqs[f], b) || rl_last[idx] !== (b == lens[f] - 1) || rl_seq[idx] != seqs[f]) begin
          n_err++;
          $display("FAIL replay_beat%0d: data %h last %0d seq %0d required %h/%0d/%0d", idx, rl_data[idx], rl_last[idx], rl_seq[idx],
                   mkdata(seqs[f], b), (b == lens[f] - 1), seqs[f]);
        end
        idx++;
      end
    n_vec++;
    if (both_seen !== 1'b0) begin n_err++; $display("FAIL replay_we_re: both asserted=%b required 0", both_seen); end
    n_vec++;
    if (rtx_busy !== 1'b0 || free_cnt !== 4'd5) begin n_err++; $display("FAIL replay_end: busy %b free %0d required 0/5", rtx_busy, free_cnt); end
  endtask

  task automatic test_req_mid_capture();
    do_reset();
    send_frame(30, 2);
    rl_data.delete(); rl_last.delete(); rl_seq.delete();
    rpl_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cap_valid = 1'b1; cap_seq = 22'd31; cap_data = mkdata(31, b); cap_last = (b == 3); rtx_req = (b == 1);
      @(negedge clk);
      if (b == 2) begin
        n_vec++;
        if (rtx_busy !== 1'b1 || cap_ready !== 1'b1 || re !== 1'b0) begin
          n_err++; $display("FAIL midcap_hold: busy %b ready %b re %b required 1/1/0", rtx_busy, cap_ready, re);
        end
      end
      @(posedge clk); #1;
    end
    cap_valid = 1'b0; cap_last = 1'b0; rtx_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (re !== 1'b0 || rpl_valid !== 1'b0 || cap_ready !== 1'b0) begin
      n_err++; $display("FAIL midcap_start: re %b valid %b ready %b required 0/0/0", re, rpl_valid, cap_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (re !== 1'b1 || rpl_valid !== 1'b0 || rdaddr !== 9'd0) begin
      n_err++; $display("FAIL midcap_first_read: re %b valid %b rdaddr %0d required 1/0/0", re, rpl_valid, rdaddr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (rpl_valid !== 1'b1 || rpl_seq !== 22'd30 || rpl_data !== mkdata(30, 0)) begin
      n_err++; $display("FAIL midcap_first_beat: valid %b seq %0d data %h required 1/30/%h", rpl_valid, rpl_seq, rpl_data, mkdata(30, 0));
    end
    @(posedge clk); #1;
    wait_idle(1'b0);
    n_vec++;
    if (rl_data.size() != 6) begin n_err++; $display("FAIL midcap_count: got %0d required 6", rl_data.size()); end
    else begin
      n_vec++;
      if (rl_seq[5] != 31 || rl_last[5] !== 1'b1 || rl_data[5] !== mkdata(31, 3) || rl_last[1] !== 1'b1) begin
        n_err++; $display("FAIL midcap_tail: seq %0d last %0d/%0d data %h required 31/1/1 %h", rl_seq[5], rl_last[5], rl_last[1], rl_data[5], mkdata(31, 3));
      end
    end
    n_vec++;
    if (rtx_cnt !== 16'(STATS)) begin n_err++; $display("FAIL midcap_rtx_cnt: got %0d required %0d", rtx_cnt, STATS); end
  endtask

  task automatic test_overflow();
    int nlast = 0;
    do_reset();
    wr_log.delete();
    ovf_cnt = 0;
    send_frame(40, 70);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ovf_cnt != 1) begin n_err++; $display("FAIL ovf_pulses: got %0d required 1", ovf_cnt); end
    n_vec++;
    if (wr_log.size() != 64 || wr_log[wr_log.size() - 1] != 63) begin
      n_err++; $display("FAIL ovf_writes: got %0d writes required 64 ending at 63", wr_log.size());
    end
    n_vec++;
    if (free_cnt !== 4'd7) begin n_err++; $display("FAIL ovf_commit: free %0d required 7", free_cnt); end
    run_replay(1'b0);
    foreach (rl_last[i]) if (rl_last[i]) nlast++;
    n_vec++;
    if (rl_data.size() != 64 || nlast != 1) begin
      n_err++; $display("FAIL ovf_replay: got %0d beats %0d lasts required 64/1", rl_data.size(), nlast);
    end else begin
      n_vec++;
      if (rl_last[63] !== 1'b1 || rl_data[63] !== mkdata(40, 63)) begin
        n_err++; $display("FAIL ovf_replay_end: last %0d data %h required 1 %h", rl_last[63], rl_data[63], mkdata(40, 63));
      end
    end
  endtask

  task automatic test_ack_wrap();
    do_reset();
    send_frame(4194303, 1);
    send_frame(0, 1);
    ack_pulse(0);
    @(negedge clk);
    n_vec++;
    if (free_cnt !== 4'd8) begin n_err++; $display("FAIL ack_wrap_free: got %0d required 8", free_cnt); end
    @(posedge clk); #1;
    send_frame(5, 1);
    ack_pulse(2097160);
    @(negedge clk);
    n_vec++;
    if (free_cnt !== 4'd7) begin n_err++; $display("FAIL ack_far_ahead: got %0d required 7", free_cnt); end
    @(posedge clk); #1;
    ack_pulse(2097156);
    @(negedge clk);
    n_vec++;
    if (free_cnt !== 4'd8) begin n_err++; $display("FAIL ack_half_edge: got %0d required 8", free_cnt); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_full();
    test_replay();
    test_req_mid_capture();
    test_overflow();
    test_ack_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
